// File: rtl/alu_seq_pkg.sv
// Shared types and defaults for the ALU input sequencer.
// Holds the state encoding (also driven onto the stage LEDs) and the default widths.
package alu_seq_pkg;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_OP_WIDTH = 3;

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } state_t;

endpackage

// File: rtl/alu_input_sequencer_rise_detect.sv
// Rising-edge detector for a debounced button level.
// Ports: clk, reset (sync, active-high), level in, pulse out (one cycle on 0->1).
// The history register resets to 1 so a button held through reset gives no pulse.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic level_q;

  always_ff @(posedge clk) begin
    if (reset) level_q <= 1'b1;
    else       level_q <= level;
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/alu_input_sequencer.sv
// Steps the shared data_in bus into ALU operands A, B and OP, then captures and holds the result.
// Ports: clk, reset (sync, active-high), data_in, enter/back buttons, alu_result/alu_error from the ALU,
// a_out/b_out/op_out to the ALU, display_value/display_error/result_valid/stage for the board display.
// Define UNDO_EN to let a rising edge on back step the sequence back one state.
module alu_input_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int OP_WIDTH = DEF_OP_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    data_in,
  input  logic                enter,
  input  logic                back,
  input  logic [WIDTH:0]      alu_result,
  input  logic                alu_error,
  output logic [WIDTH-1:0]    a_out,
  output logic [WIDTH-1:0]    b_out,
  output logic [OP_WIDTH-1:0] op_out,
  output logic [WIDTH:0]      display_value,
  output logic                display_error,
  output logic                result_valid,
  output logic [2:0]          stage
);

  state_t         state;
  logic [WIDTH:0] res_q;
  logic           err_q;
  logic           enter_press;
  logic           back_press;

  rise_detect u_enter (
    .clk   (clk),
    .reset (reset),
    .level (enter),
    .pulse (enter_press)
  );

`ifdef UNDO_EN
  rise_detect u_back (
    .clk   (clk),
    .reset (reset),
    .level (back),
    .pulse (back_press)
  );
`else
  logic unused_back;
  assign unused_back = back;
  assign back_press  = 1'b0;
`endif

  // enter always takes priority over back in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= LOAD_A;
      a_out  <= '0;
      b_out  <= '0;
      op_out <= '0;
      res_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        LOAD_A: begin
          if (enter_press) begin
            a_out <= data_in;
            state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (enter_press) begin
            b_out <= data_in;
            state <= LOAD_OP;
          end else if (back_press) begin
            state <= LOAD_A;
          end
        end
        LOAD_OP: begin
          if (enter_press) begin
            op_out <= data_in[OP_WIDTH-1:0];
            state  <= EXEC;
          end else if (back_press) begin
            state <= LOAD_B;
          end
        end
        EXEC: begin
          // ALU has settled on the op_out written last cycle.
          res_q <= alu_result;
          err_q <= alu_error;
          state <= SHOW;
        end
        SHOW: begin
          if (enter_press) begin
            res_q <= '0;
            err_q <= 1'b0;
            state <= LOAD_A;
          end else if (back_press) begin
            res_q <= '0;
            err_q <= 1'b0;
            state <= LOAD_OP;
          end
        end
        default: state <= LOAD_A;
      endcase
    end
  end

  always_comb begin
    display_value = res_q;
    if (state == LOAD_A || state == LOAD_B || state == LOAD_OP)
      display_value = {1'b0, data_in};
  end

  assign result_valid  = (state == SHOW);
  assign display_error = result_valid & err_q;
  assign stage         = state;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Self-checking bench for alu_input_sequencer with a behavioural ALU stand-in.
// Operand/result expectations come from the values the bench applied and plain ALU arithmetic.
module tb_alu_input_sequencer;

  logic        clk;
  logic        reset;
  logic [15:0] data_in;
  logic        enter;
  logic        back;
  logic [16:0] alu_result;
  logic        alu_error;
  logic [15:0] a_out;
  logic [15:0] b_out;
  logic [2:0]  op_out;
  logic [16:0] display_value;
  logic        display_error;
  logic        result_valid;
  logic [2:0]  stage;

  int vectors;
  int miscompares;

  alu_input_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .data_in       (data_in),
    .enter         (enter),
    .back          (back),
    .alu_result    (alu_result),
    .alu_error     (alu_error),
    .a_out         (a_out),
    .b_out         (b_out),
    .op_out        (op_out),
    .display_value (display_value),
    .display_error (display_error),
    .result_valid  (result_valid),
    .stage         (stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL A, 7 illegal.
  function automatic logic [17:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [2:0] op);
    int unsigned r;
    logic e;
    e = 1'b0;
    case (op)
      3'd0: r = (int'(a) + int'(b)) % 131072;
      3'd1: r = (int'(a) - int'(b) + 131072) % 131072;
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
      3'd4: r = int'(a ^ b);
      3'd5: r = 65535 - int'(a);
      3'd6: r = int'(a) * 2;
      default: begin r = 0; e = 1'b1; end
    endcase
    return {e, 17'(r)};
  endfunction

  always_comb {alu_error, alu_result} = alu_fn(a_out, b_out, op_out);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [15:0] d);
    data_in = d;
    enter = 1'b1;
    tick();
    enter = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; enter = 1'b0; back = 1'b0; data_in = 16'h1234;
    tick(); tick();
    reset = 1'b0;
    tick();
    vectors++;
    if (stage !== 3'd0 || a_out !== 16'h0 || b_out !== 16'h0 || op_out !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_regs: got stage=%0d a=%h b=%h op=%0d, want 0/0/0/0",
               stage, a_out, b_out, op_out);
    end
    vectors++;
    if (result_valid !== 1'b0 || display_error !== 1'b0 || display_value !== 17'h01234) begin
      miscompares++;
      $display("FAIL reset_display: got rv=%b err=%b val=%h, want 0/0/01234",
               result_valid, display_error, display_value);
    end
  endtask

  task automatic test_basic_add();
    press(16'h0005);
    vectors++;
    if (a_out !== 16'h0005 || stage !== 3'd1) begin
      miscompares++;
      $display("FAIL load_a: got a=%h stage=%0d, want 0005/1", a_out, stage);
    end
    press(16'h0003);
    vectors++;
    if (b_out !== 16'h0003 || stage !== 3'd2) begin
      miscompares++;
      $display("FAIL load_b: got b=%h stage=%0d, want 0003/2", b_out, stage);
    end
    data_in = 16'h0000;
    enter = 1'b1;
    tick();
    vectors++;
    if (stage !== 3'd3 || result_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL exec_cycle: got stage=%0d rv=%b, want 3/0", stage, result_valid);
    end
    enter = 1'b0;
    tick();
    vectors++;
    if (result_valid !== 1'b1 || display_value !== 17'h00008 || display_error !== 1'b0) begin
      miscompares++;
      $display("FAIL add_result: got rv=%b val=%h err=%b, want 1/00008/0",
               result_valid, display_value, display_error);
    end
  endtask

  task automatic test_carry_hold();
    press(16'h0000);
    vectors++;
    if (stage !== 3'd0 || result_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL leave_show: got stage=%0d rv=%b, want 0/0", stage, result_valid);
    end
    press(16'hFFFF);
    press(16'h0001);
    press(16'h0000);
    vectors++;
    if (display_value !== 17'h10000 || result_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL carry: got val=%h rv=%b, want 10000/1", display_value, result_valid);
    end
    data_in = 16'hABCD;
    tick(); tick();
    vectors++;
    if (display_value !== 17'h10000 || stage !== 3'd4) begin
      miscompares++;
      $display("FAIL show_hold: got val=%h stage=%0d, want 10000/4", display_value, stage);
    end
  endtask

  task automatic test_enter_held_reset();
    reset = 1'b1; enter = 1'b1; data_in = 16'h0007;
    tick(); tick();
    reset = 1'b0;
    tick(); tick(); tick();
    vectors++;
    if (stage !== 3'd0 || a_out !== 16'h0000) begin
      miscompares++;
      $display("FAIL held_enter: got stage=%0d a=%h, want 0/0000", stage, a_out);
    end
    enter = 1'b0;
    tick();
    enter = 1'b1;
    tick();
    vectors++;
    if (stage !== 3'd1 || a_out !== 16'h0007) begin
      miscompares++;
      $display("FAIL repress: got stage=%0d a=%h, want 1/0007", stage, a_out);
    end
    enter = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    press(16'h0022);
    press(16'h0003);
    vectors++;
    if (stage !== 3'd3 && stage !== 3'd4) begin
      miscompares++;
      $display("FAIL mid_seq_setup: got stage=%0d, want 3 or 4", stage);
    end
    press(16'h0000);
    press(16'h0011);
    press(16'h0022);
    vectors++;
    if (stage !== 3'd2 || a_out !== 16'h0011 || b_out !== 16'h0022) begin
      miscompares++;
      $display("FAIL mid_seq_load: got stage=%0d a=%h b=%h, want 2/0011/0022",
               stage, a_out, b_out);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (stage !== 3'd0 || a_out !== 16'h0 || b_out !== 16'h0 || op_out !== 3'd0) begin
      miscompares++;
      $display("FAIL mid_reset: got stage=%0d a=%h b=%h op=%0d, want 0/0/0/0",
               stage, a_out, b_out, op_out);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    press(16'h0100);
    press(16'h00F0);
    data_in = 16'h0003;
    enter = 1'b1;
    tick(); tick(); tick(); tick();
    vectors++;
    if (stage !== 3'd4 || display_value !== 17'h001F0) begin
      miscompares++;
      $display("FAIL exec_press_ignored: got stage=%0d val=%h, want 4/001F0",
               stage, display_value);
    end
    enter = 1'b0;
    tick();
    press(16'h5555);
    vectors++;
    if (stage !== 3'd0 || a_out !== 16'h0100 || b_out !== 16'h00F0 || op_out !== 3'd3) begin
      miscompares++;
      $display("FAIL show_press: got stage=%0d a=%h b=%h op=%0d, want 0/0100/00F0/3",
               stage, a_out, b_out, op_out);
    end
    vectors++;
    if (display_value !== 17'h05555 || display_error !== 1'b0) begin
      miscompares++;
      $display("FAIL show_clear: got val=%h err=%b, want 05555/0", display_value, display_error);
    end
  endtask

  task automatic test_undo();
    press(16'h1111);
    press(16'h2222);
    back = 1'b1;
    tick();
    back = 1'b0;
    tick();
`ifdef UNDO_EN
    vectors++;
    if (stage !== 3'd1 || b_out !== 16'h2222) begin
      miscompares++;
      $display("FAIL undo_op: got stage=%0d b=%h, want 1/2222", stage, b_out);
    end
    press(16'h3333);
    data_in = 16'h0000;
    enter = 1'b1;
    back = 1'b1;
    tick();
    vectors++;
    if (stage !== 3'd3) begin
      miscompares++;
      $display("FAIL enter_wins: got stage=%0d, want 3", stage);
    end
    enter = 1'b0;
    back = 1'b0;
    tick();
    vectors++;
    if (display_value !== 17'h04444 || result_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL undo_result: got val=%h rv=%b, want 04444/1", display_value, result_valid);
    end
    back = 1'b1;
    tick();
    back = 1'b0;
    tick();
    vectors++;
    if (stage !== 3'd2 || result_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL undo_show: got stage=%0d rv=%b, want 2/0", stage, result_valid);
    end
`else
    vectors++;
    if (stage !== 3'd2 || b_out !== 16'h2222) begin
      miscompares++;
      $display("FAIL back_ignored: got stage=%0d b=%h, want 2/2222", stage, b_out);
    end
`endif
    press(16'h0001);
    press(16'h0000);
    back = 1'b1;
    tick();
    back = 1'b0;
    tick();
    vectors++;
    if (stage !== 3'd0) begin
      miscompares++;
      $display("FAIL back_in_load_a: got stage=%0d, want 0", stage);
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b, noise;
    logic [2:0]  op;
    logic [17:0] exp;
    for (int i = 0; i < 25; i++) begin
      a  = 16'($urandom);
      b  = 16'($urandom);
      op = 3'($urandom_range(0, 7));
      exp = alu_fn(a, b, op);
      repeat ($urandom_range(0, 2)) tick();
      press(a);
      repeat ($urandom_range(0, 2)) tick();
      press(b);
      vectors++;
      if (a_out !== a || b_out !== b || stage !== 3'd2) begin
        miscompares++;
        $display("FAIL rnd_load[%0d]: got a=%h b=%h stage=%0d, want %h/%h/2",
                 i, a_out, b_out, stage, a, b);
      end
      repeat ($urandom_range(0, 2)) tick();
      press({13'($urandom), op});
      vectors++;
      if (result_valid !== 1'b1 || display_value !== exp[16:0] || display_error !== exp[17]) begin
        miscompares++;
        $display("FAIL rnd_result[%0d]: got rv=%b val=%h err=%b, want 1/%h/%b",
                 i, result_valid, display_value, display_error, exp[16:0], exp[17]);
      end
      noise = 16'($urandom);
      data_in = noise;
      tick();
      vectors++;
      if (display_value !== exp[16:0] || display_error !== exp[17]) begin
        miscompares++;
        $display("FAIL rnd_hold[%0d]: got val=%h err=%b, want %h/%b",
                 i, display_value, display_error, exp[16:0], exp[17]);
      end
      press(noise);
      vectors++;
      if (stage !== 3'd0 || a_out !== a || display_value !== {1'b0, noise}) begin
        miscompares++;
        $display("FAIL rnd_leave[%0d]: got stage=%0d a=%h val=%h, want 0/%h/%h",
                 i, stage, a_out, display_value, a, {1'b0, noise});
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    enter = 1'b0;
    back = 1'b0;
    data_in = '0;
    test_reset();
    test_basic_add();
    test_carry_hold();
    test_enter_held_reset();
    test_reset_mid();
    test_back_to_back();
    test_undo();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
